// File: rtl/cu_sequencer.sv
// RAT CPU control sequencer: INIT/FETCH/EXEC/INTER stepping, decoder strobe gating,
// conditional branch resolution and external interrupt capture.
module cu_sequencer #(
  parameter int RST_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SEQ_INT_IN,
  input  logic       SEQ_I_FLAG,
  input  logic       SEQ_C,
  input  logic       SEQ_Z,
  input  logic       DEC_PC_LD,
  input  logic       DEC_SP_LD,
  input  logic       DEC_SP_INCR,
  input  logic       DEC_SP_DECR,
  input  logic       DEC_RF_WR,
  input  logic       DEC_SCR_WE,
  input  logic       DEC_SCR_DATA_SEL,
  input  logic       DEC_FLG_C_SET,
  input  logic       DEC_FLG_C_CLR,
  input  logic       DEC_FLG_C_LD,
  input  logic       DEC_FLG_Z_LD,
  input  logic       DEC_I_SET,
  input  logic       DEC_I_CLR,
  input  logic       DEC_IO_STRB,
  input  logic       DEC_COND_BRN,
  input  logic [1:0] DEC_PC_MUX_SEL,
  input  logic [1:0] DEC_SCR_ADDR_SEL,
  input  logic [1:0] DEC_COND_BRN_TYPE,
  output logic       SEQ_PC_LD,
  output logic       SEQ_SP_LD,
  output logic       SEQ_SP_INCR,
  output logic       SEQ_SP_DECR,
  output logic       SEQ_RF_WR,
  output logic       SEQ_SCR_WE,
  output logic       SEQ_SCR_DATA_SEL,
  output logic       SEQ_FLG_C_SET,
  output logic       SEQ_FLG_C_CLR,
  output logic       SEQ_FLG_C_LD,
  output logic       SEQ_FLG_Z_LD,
  output logic       SEQ_I_SET,
  output logic       SEQ_I_CLR,
  output logic       SEQ_IO_STRB,
  output logic [1:0] SEQ_PC_MUX_SEL,
  output logic [1:0] SEQ_SCR_ADDR_SEL,
  output logic       SEQ_PC_INC,
  output logic       SEQ_IR_LD,
  output logic       SEQ_RST,
  output logic       SEQ_FLG_SHAD_LD,
  output logic       SEQ_INT_ACK
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    INTER = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] rst_cnt;
  logic             rst_done;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             int_edge;
  logic             int_pend;
  logic             cond_met;
  logic             brn_taken;

  // Counter stops at the exit value so INIT never re-arms without a fresh reset.
  assign rst_done = (rst_cnt >= CNT_W'(RST_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= INIT;
      rst_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && !rst_done)
        rst_cnt <= rst_cnt + CNT_W'(1);
    end
  end

  // Two-flop synchronizer plus a history flop; a new edge beats the INTER clear.
  assign int_edge = s2 & ~s3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      s1 <= SEQ_INT_IN;
      s2 <= s1;
      s3 <= s2;
      if (int_edge)
        int_pend <= 1'b1;
      else if (state == INTER)
        int_pend <= 1'b0;
    end
  end

  always_comb begin
    cond_met = 1'b0;
    case (DEC_COND_BRN_TYPE)
      2'b00:   cond_met = ~SEQ_C;
      2'b01:   cond_met = SEQ_C;
      2'b10:   cond_met = SEQ_Z;
      default: cond_met = ~SEQ_Z;
    endcase
    brn_taken = DEC_COND_BRN & cond_met;
  end

  always_comb begin
    state_next       = state;
    SEQ_PC_LD        = 1'b0;
    SEQ_SP_LD        = 1'b0;
    SEQ_SP_INCR      = 1'b0;
    SEQ_SP_DECR      = 1'b0;
    SEQ_RF_WR        = 1'b0;
    SEQ_SCR_WE       = 1'b0;
    SEQ_SCR_DATA_SEL = 1'b0;
    SEQ_FLG_C_SET    = 1'b0;
    SEQ_FLG_C_CLR    = 1'b0;
    SEQ_FLG_C_LD     = 1'b0;
    SEQ_FLG_Z_LD     = 1'b0;
    SEQ_I_SET        = 1'b0;
    SEQ_I_CLR        = 1'b0;
    SEQ_IO_STRB      = 1'b0;
    SEQ_PC_MUX_SEL   = 2'b00;
    SEQ_SCR_ADDR_SEL = 2'b00;
    SEQ_PC_INC       = 1'b0;
    SEQ_IR_LD        = 1'b0;
    SEQ_RST          = 1'b0;
    SEQ_FLG_SHAD_LD  = 1'b0;
    SEQ_INT_ACK      = 1'b0;

    case (state)
      INIT: begin
        SEQ_RST = 1'b1;
        if (rst_done)
          state_next = FETCH;
      end

      FETCH: begin
        SEQ_IR_LD  = 1'b1;
        SEQ_PC_INC = 1'b1;
        state_next = EXEC;
      end

      EXEC: begin
        SEQ_PC_LD        = DEC_PC_LD;
        SEQ_SP_LD        = DEC_SP_LD;
        SEQ_SP_INCR      = DEC_SP_INCR;
        SEQ_SP_DECR      = DEC_SP_DECR;
        SEQ_RF_WR        = DEC_RF_WR;
        SEQ_SCR_WE       = DEC_SCR_WE;
        SEQ_SCR_DATA_SEL = DEC_SCR_DATA_SEL;
        SEQ_FLG_C_SET    = DEC_FLG_C_SET;
        SEQ_FLG_C_CLR    = DEC_FLG_C_CLR;
        SEQ_FLG_C_LD     = DEC_FLG_C_LD;
        SEQ_FLG_Z_LD     = DEC_FLG_Z_LD;
        SEQ_I_SET        = DEC_I_SET;
        SEQ_I_CLR        = DEC_I_CLR;
        SEQ_IO_STRB      = DEC_IO_STRB;
        SEQ_PC_MUX_SEL   = DEC_PC_MUX_SEL;
        SEQ_SCR_ADDR_SEL = DEC_SCR_ADDR_SEL;
        if (brn_taken) begin
          SEQ_PC_LD      = 1'b1;
          SEQ_PC_MUX_SEL = 2'b00;
        end
        // CLI/RETID clear I in this very EXEC, so they must block entry.
        if (int_pend && SEQ_I_FLAG && !DEC_I_CLR)
          state_next = INTER;
        else
          state_next = FETCH;
      end

      INTER: begin
        SEQ_FLG_SHAD_LD  = 1'b1;
        SEQ_PC_LD        = 1'b1;
        SEQ_SP_DECR      = 1'b1;
        SEQ_SCR_WE       = 1'b1;
        SEQ_SCR_DATA_SEL = 1'b1;
        SEQ_I_CLR        = 1'b1;
        SEQ_INT_ACK      = 1'b1;
        SEQ_PC_MUX_SEL   = 2'b10;
        SEQ_SCR_ADDR_SEL = 2'b11;
        state_next       = FETCH;
      end

      default: state_next = INIT;
    endcase
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: reset, pass-through gating, branches and interrupt entry.
module tb_cu_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       SEQ_INT_IN, SEQ_I_FLAG, SEQ_C, SEQ_Z;
  logic       DEC_PC_LD, DEC_SP_LD, DEC_SP_INCR, DEC_SP_DECR, DEC_RF_WR;
  logic       DEC_SCR_WE, DEC_SCR_DATA_SEL, DEC_FLG_C_SET, DEC_FLG_C_CLR;
  logic       DEC_FLG_C_LD, DEC_FLG_Z_LD, DEC_I_SET, DEC_I_CLR, DEC_IO_STRB;
  logic       DEC_COND_BRN;
  logic [1:0] DEC_PC_MUX_SEL, DEC_SCR_ADDR_SEL, DEC_COND_BRN_TYPE;
  logic       SEQ_PC_LD, SEQ_SP_LD, SEQ_SP_INCR, SEQ_SP_DECR, SEQ_RF_WR;
  logic       SEQ_SCR_WE, SEQ_SCR_DATA_SEL, SEQ_FLG_C_SET, SEQ_FLG_C_CLR;
  logic       SEQ_FLG_C_LD, SEQ_FLG_Z_LD, SEQ_I_SET, SEQ_I_CLR, SEQ_IO_STRB;
  logic [1:0] SEQ_PC_MUX_SEL, SEQ_SCR_ADDR_SEL;
  logic       SEQ_PC_INC, SEQ_IR_LD, SEQ_RST, SEQ_FLG_SHAD_LD, SEQ_INT_ACK;

  int checks;
  int failures;

  // Bit map: 22 PC_LD 21 SP_LD 20 SP_INCR 19 SP_DECR 18 RF_WR 17 SCR_WE 16 SCR_DATA_SEL
  // 15 C_SET 14 C_CLR 13 C_LD 12 Z_LD 11 I_SET 10 I_CLR 9 IO_STRB 8:7 PC_MUX 6:5 SCR_ADDR
  // 4 PC_INC 3 IR_LD 2 RST 1 SHAD_LD 0 INT_ACK
  logic [22:0] out_vec;
  assign out_vec = {SEQ_PC_LD, SEQ_SP_LD, SEQ_SP_INCR, SEQ_SP_DECR, SEQ_RF_WR,
                    SEQ_SCR_WE, SEQ_SCR_DATA_SEL, SEQ_FLG_C_SET, SEQ_FLG_C_CLR,
                    SEQ_FLG_C_LD, SEQ_FLG_Z_LD, SEQ_I_SET, SEQ_I_CLR, SEQ_IO_STRB,
                    SEQ_PC_MUX_SEL, SEQ_SCR_ADDR_SEL, SEQ_PC_INC, SEQ_IR_LD,
                    SEQ_RST, SEQ_FLG_SHAD_LD, SEQ_INT_ACK};

  localparam logic [22:0] E_IDLE  = 23'h0;
  localparam logic [22:0] E_INIT  = 23'(1 << 2);
  localparam logic [22:0] E_FETCH = 23'((1 << 4) | (1 << 3));
  localparam logic [22:0] E_INTER = 23'((1 << 22) | (1 << 19) | (1 << 17) | (1 << 16) |
                                        (1 << 10) | (1 << 8) | (3 << 5) | (1 << 1) | 1);

  cu_sequencer #(.RST_CYCLES(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .SEQ_INT_IN(SEQ_INT_IN), .SEQ_I_FLAG(SEQ_I_FLAG),
    .SEQ_C(SEQ_C), .SEQ_Z(SEQ_Z),
    .DEC_PC_LD(DEC_PC_LD), .DEC_SP_LD(DEC_SP_LD), .DEC_SP_INCR(DEC_SP_INCR),
    .DEC_SP_DECR(DEC_SP_DECR), .DEC_RF_WR(DEC_RF_WR), .DEC_SCR_WE(DEC_SCR_WE),
    .DEC_SCR_DATA_SEL(DEC_SCR_DATA_SEL), .DEC_FLG_C_SET(DEC_FLG_C_SET),
    .DEC_FLG_C_CLR(DEC_FLG_C_CLR), .DEC_FLG_C_LD(DEC_FLG_C_LD),
    .DEC_FLG_Z_LD(DEC_FLG_Z_LD), .DEC_I_SET(DEC_I_SET), .DEC_I_CLR(DEC_I_CLR),
    .DEC_IO_STRB(DEC_IO_STRB), .DEC_COND_BRN(DEC_COND_BRN),
    .DEC_PC_MUX_SEL(DEC_PC_MUX_SEL), .DEC_SCR_ADDR_SEL(DEC_SCR_ADDR_SEL),
    .DEC_COND_BRN_TYPE(DEC_COND_BRN_TYPE),
    .SEQ_PC_LD(SEQ_PC_LD), .SEQ_SP_LD(SEQ_SP_LD), .SEQ_SP_INCR(SEQ_SP_INCR),
    .SEQ_SP_DECR(SEQ_SP_DECR), .SEQ_RF_WR(SEQ_RF_WR), .SEQ_SCR_WE(SEQ_SCR_WE),
    .SEQ_SCR_DATA_SEL(SEQ_SCR_DATA_SEL), .SEQ_FLG_C_SET(SEQ_FLG_C_SET),
    .SEQ_FLG_C_CLR(SEQ_FLG_C_CLR), .SEQ_FLG_C_LD(SEQ_FLG_C_LD),
    .SEQ_FLG_Z_LD(SEQ_FLG_Z_LD), .SEQ_I_SET(SEQ_I_SET), .SEQ_I_CLR(SEQ_I_CLR),
    .SEQ_IO_STRB(SEQ_IO_STRB), .SEQ_PC_MUX_SEL(SEQ_PC_MUX_SEL),
    .SEQ_SCR_ADDR_SEL(SEQ_SCR_ADDR_SEL), .SEQ_PC_INC(SEQ_PC_INC),
    .SEQ_IR_LD(SEQ_IR_LD), .SEQ_RST(SEQ_RST), .SEQ_FLG_SHAD_LD(SEQ_FLG_SHAD_LD),
    .SEQ_INT_ACK(SEQ_INT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every task enters and leaves one time unit after a rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_dec();
    {DEC_PC_LD, DEC_SP_LD, DEC_SP_INCR, DEC_SP_DECR, DEC_RF_WR, DEC_SCR_WE,
     DEC_SCR_DATA_SEL, DEC_FLG_C_SET, DEC_FLG_C_CLR, DEC_FLG_C_LD, DEC_FLG_Z_LD,
     DEC_I_SET, DEC_I_CLR, DEC_IO_STRB, DEC_COND_BRN} = '0;
    DEC_PC_MUX_SEL    = 2'b00;
    DEC_SCR_ADDR_SEL  = 2'b00;
    DEC_COND_BRN_TYPE = 2'b00;
  endtask

  task automatic sync_fetch(input string tag);
    int n;
    n = 0;
    while (SEQ_IR_LD !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    if (SEQ_IR_LD !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_fetch_timeout got IR_LD=%b required=1", tag, SEQ_IR_LD);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    SEQ_INT_IN = 1'b0; SEQ_I_FLAG = 1'b0; SEQ_C = 1'b0; SEQ_Z = 1'b0;
    clear_dec();
    cyc(); cyc();
    checks++;
    if (out_vec !== E_INIT) begin
      failures++;
      $display("FAIL reset_held got=%h required=%h", out_vec, E_INIT);
    end
    RST_N = 1'b1;
    #1;
    checks++;
    if (out_vec !== E_INIT) begin
      failures++;
      $display("FAIL reset_init_cycle got=%h required=%h", out_vec, E_INIT);
    end
    cyc();
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL reset_first_fetch got=%h required=%h", out_vec, E_FETCH);
    end
    cyc();
    checks++;
    if (out_vec !== E_IDLE) begin
      failures++;
      $display("FAIL reset_first_exec got=%h required=%h", out_vec, E_IDLE);
    end
  endtask

  task automatic test_add_rf_wr();
    sync_fetch("add");
    DEC_RF_WR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i % 2 == 0) begin
        if (out_vec !== E_FETCH) begin
          failures++;
          $display("FAIL add_fetch_%0d got=%h required=%h", i, out_vec, E_FETCH);
        end
      end else begin
        if (out_vec !== 23'(1 << 18)) begin
          failures++;
          $display("FAIL add_exec_%0d got=%h required=%h", i, out_vec, 23'(1 << 18));
        end
      end
      cyc();
    end
    clear_dec();
  endtask

  task automatic test_branch();
    // {type, C, Z, taken}: BRCC, BRCC, BREQ, BRNE, BRCS, BRNE
    logic [4:0] vec [6] = '{5'b00_0_0_1, 5'b00_1_0_0, 5'b10_0_1_1,
                            5'b11_0_1_0, 5'b01_1_0_1, 5'b11_1_0_1};
    logic [22:0] exp;
    for (int i = 0; i < 6; i++) begin
      sync_fetch("branch");
      DEC_COND_BRN      = 1'b1;
      DEC_PC_MUX_SEL    = 2'b01;
      DEC_COND_BRN_TYPE = vec[i][4:3];
      SEQ_C             = vec[i][2];
      SEQ_Z             = vec[i][1];
      cyc();
      exp = vec[i][0] ? 23'(1 << 22) : 23'(1 << 7);
      checks++;
      if (out_vec !== exp) begin
        failures++;
        $display("FAIL branch_%0d got=%h required=%h", i, out_vec, exp);
      end
      cyc();
      clear_dec();
    end
    SEQ_C = 1'b0;
    SEQ_Z = 1'b0;
  endtask

  task automatic test_interrupt_taken();
    logic [22:0] exp [6] = '{E_IDLE, E_FETCH, E_IDLE, E_INTER, E_FETCH, E_IDLE};
    SEQ_I_FLAG = 1'b1;
    sync_fetch("int");
    SEQ_INT_IN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) SEQ_INT_IN = 1'b0;
      checks++;
      if (out_vec !== exp[i]) begin
        failures++;
        $display("FAIL int_taken_%0d got=%h required=%h", i, out_vec, exp[i]);
      end
    end
    cyc();
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL int_taken_once got=%h required=%h", out_vec, E_FETCH);
    end
  endtask

  task automatic test_interrupt_held_off();
    SEQ_I_FLAG = 1'b0;
    sync_fetch("held");
    SEQ_INT_IN = 1'b1;
    cyc(); cyc(); cyc();
    SEQ_INT_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_vec !== ((i % 2 == 0) ? E_FETCH : E_IDLE)) begin
        failures++;
        $display("FAIL held_off_%0d got=%h", i, out_vec);
      end
    end
    DEC_I_SET = 1'b1;
    cyc();
    checks++;
    if (out_vec !== 23'(1 << 11)) begin
      failures++;
      $display("FAIL held_sei_exec got=%h required=%h", out_vec, 23'(1 << 11));
    end
    cyc();
    clear_dec();
    SEQ_I_FLAG = 1'b1;
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL held_after_sei got=%h required=%h", out_vec, E_FETCH);
    end
    cyc();
    cyc();
    checks++;
    if (out_vec !== E_INTER) begin
      failures++;
      $display("FAIL held_then_inter got=%h required=%h", out_vec, E_INTER);
    end
    cyc();
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL held_post_inter got=%h required=%h", out_vec, E_FETCH);
    end
  endtask

  task automatic test_cli_vs_pending();
    SEQ_I_FLAG = 1'b0;
    sync_fetch("cli");
    SEQ_INT_IN = 1'b1;
    cyc(); cyc(); cyc();
    SEQ_INT_IN = 1'b0;
    sync_fetch("cli2");
    SEQ_I_FLAG = 1'b1;
    DEC_I_CLR  = 1'b1;
    cyc();
    checks++;
    if (out_vec !== 23'(1 << 10)) begin
      failures++;
      $display("FAIL cli_exec got=%h required=%h", out_vec, 23'(1 << 10));
    end
    cyc();
    clear_dec();
    SEQ_I_FLAG = 1'b0;
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL cli_no_inter got=%h required=%h", out_vec, E_FETCH);
    end
  endtask

  task automatic test_reset_during_inter();
    sync_fetch("rst_inter");
    SEQ_I_FLAG = 1'b1;
    cyc();
    cyc();
    checks++;
    if (out_vec !== E_INTER) begin
      failures++;
      $display("FAIL rst_inter_entry got=%h required=%h", out_vec, E_INTER);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (SEQ_SCR_WE !== 1'b0 || out_vec !== E_INIT) begin
      failures++;
      $display("FAIL rst_inter_drop got=%h required=%h", out_vec, E_INIT);
    end
    cyc();
    RST_N = 1'b1;
    cyc();
    cyc();
    cyc();
    checks++;
    if (out_vec !== E_FETCH) begin
      failures++;
      $display("FAIL rst_inter_pend_cleared got=%h required=%h", out_vec, E_FETCH);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_rf_wr();
    test_branch();
    test_interrupt_taken();
    test_interrupt_held_off();
    test_cli_vs_pending();
    test_reset_during_inter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
